// File: rtl/rounding_exp_decoder.sv
// Two-stage valid/ready decoder that turns a one-hot rounded operand 2^K into K,
// flagging zero and malformed (multi-hot) operands and counting malformed results.
module rounding_exp_decoder #(
    parameter int WIDTH      = 16,
    parameter int LOG2_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH:0]        Ar,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LOG2_WIDTH:0]   K_out,
    output logic                  zero,
    output logic                  err,
    output logic [15:0]           err_count
);

    logic                 r_vld_p1;
    logic [WIDTH:0]       r_ar_p1;
    logic                 r_vld_p2;
    logic [LOG2_WIDTH:0]  r_k_p2;
    logic                 r_zero_p2;
    logic                 r_err_p2;
    logic [15:0]          r_err_cnt;

    logic                 w_s1_adv;
    logic                 w_in_hs;
    logic                 w_out_hs;

    function automatic logic [LOG2_WIDTH:0] f_msb_idx(input logic [WIDTH:0] a);
        logic [LOG2_WIDTH:0] k;
        k = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            if (a[i]) k = i[LOG2_WIDTH:0];
        end
        return k;
    endfunction

    // Clearing the lowest set bit leaves something only if more than one bit was set.
    function automatic logic f_multi_hot(input logic [WIDTH:0] a);
        return (a & (a - {{WIDTH{1'b0}}, 1'b1})) != '0;
    endfunction

    function automatic logic [15:0] f_sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    assign w_s1_adv = r_vld_p1 && (!r_vld_p2 || out_ready);
    assign in_ready = !r_vld_p1 || w_s1_adv;
    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = r_vld_p2 && out_ready;

    // Stage 1: operand capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_in_hs) begin
            r_vld_p1 <= 1'b1;
        end else if (w_s1_adv) begin
            r_vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_hs) r_ar_p1 <= Ar;
    end

    // Stage 2: registered decode, held while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_k_p2    <= '0;
            r_zero_p2 <= 1'b0;
            r_err_p2  <= 1'b0;
        end else if (w_s1_adv) begin
            r_vld_p2  <= 1'b1;
            r_k_p2    <= f_msb_idx(r_ar_p1);
            r_zero_p2 <= (r_ar_p1 == '0);
            r_err_p2  <= f_multi_hot(r_ar_p1);
        end else if (out_ready) begin
            r_vld_p2  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= 16'd0;
        end else if (w_out_hs && r_err_p2) begin
            r_err_cnt <= f_sat_inc(r_err_cnt);
        end
    end

    assign out_valid = r_vld_p2;
    assign K_out     = r_k_p2;
    assign zero      = r_zero_p2;
    assign err       = r_err_p2;
    assign err_count = r_err_cnt;

endmodule

// File: doc/rounding_exp_decoder.md
# rounding_exp_decoder

Pipelined decoder on the consumer side of the power-of-two rounding path. It accepts a rounded operand (a one-hot value 2^K, WIDTH+1 bits wide) and recovers the exponent K for the shift-based log multiplier datapath. It also flags zero operands and malformed (non-one-hot) operands. Data moves through a 2-stage valid/ready pipeline, and the block keeps a saturating count of malformed inputs.

## Interface
Parameters:
- WIDTH, 16, width of the unrounded operand; the rounded input is WIDTH+1 bits.
- LOG2_WIDTH, 4, log2(WIDTH); the exponent output is LOG2_WIDTH+1 bits so it can represent K = WIDTH.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  Ar holds a valid rounded operand.
- in_ready  output  1  block can accept Ar this cycle.
- Ar  input  WIDTH+1  rounded operand; legal values are 0 or a single set bit.
- out_valid  output  1  K_out, zero and err are valid.
- out_ready  input  1  downstream accepts the result this cycle.
- K_out  output  LOG2_WIDTH+1  index of the highest set bit of Ar.
- zero  output  1  Ar was all zeros.
- err  output  1  Ar had more than one bit set.
- err_count  output  16  saturating count of err results accepted downstream.

## Operation
- Stage 1 (S1): captures Ar on an input handshake (in_valid && in_ready). Sets s1_valid.
- Stage 2 (S2): registers the decode of the S1 contents:
  - K_out = highest set-bit index.
  - zero = (Ar == 0); K_out = 0 when zero.
  - err = popcount(Ar) > 1; K_out is still the highest set bit.
- S1 advances into S2 when s1_valid && (!s2_valid || out_ready).
- in_ready = !s1_valid || S1 advances. This is combinational from registered state and out_ready, and must not depend on in_valid.
- out_valid = s2_valid. K_out, zero and err are driven directly from S2 registers.
- If out_ready is low while S2 holds a result, S2 holds it: its outputs stay stable and out_valid stays high.
- err_count increments by 1 on each cycle with out_valid && out_ready && err, and saturates at 16'hFFFF.
- No data-path states beyond the two valid bits. Pipeline occupancy is 0, 1 or 2 entries.

## Timing
- Reset values, all asynchronous: s1_valid = 0, s2_valid = 0, out_valid = 0, K_out = 0, zero = 0, err = 0, err_count = 0.
- in_ready reads 1 while rst is high and after rst is released.
- Latency: an operand accepted on edge N is presented at the outputs (out_valid = 1) after edge N+1.
- Throughput: 1 operand per cycle while out_ready = 1.
- Full pipeline (both stages valid) with out_ready = 0: in_ready = 0, and nothing is lost or duplicated.
- Full pipeline with out_ready = 1: simultaneous output handshake, S1 to S2 move, and new input capture, all on the same edge.
- Empty S2 with out_ready = 0: S1 still advances into S2, so a bubble never blocks.
- Reset mid-operation: all in-flight entries are discarded and err_count clears. The first result after reset comes from an operand accepted after rst deasserts.
- Saturation: with err_count = 16'hFFFF, further err handshakes leave it at 16'hFFFF.

## Test plan
- Single operand, WIDTH=16: Ar = 17'h00080 with out_ready = 1 -> two cycles later out_valid = 1, K_out = 7, zero = 0, err = 0.
- Boundary values:
  - Ar = 17'h10000 -> K_out = 16.
  - Ar = 17'h00001 -> K_out = 0, zero = 0.
  - Ar = 0 -> K_out = 0, zero = 1.
- Malformed input: Ar = 17'h00006 -> K_out = 2, err = 1, err_count goes 0 -> 1 on acceptance. A preloaded err_count of 16'hFFFF plus one more err stays at 16'hFFFF.
- Backpressure: stream 2^0..2^9 back-to-back while out_ready is held low for 5 cycles -> in_ready drops after 2 accepts. Outputs then appear in order K = 0..9 with no loss or duplication, and K_out stays stable while stalled.
- Full throughput: 100 random legal one-hot inputs with in_valid = out_ready = 1 -> one result per cycle, each matching log2 of the input, fixed 2-cycle latency.
- Reset mid-stream: assert rst asynchronously with 2 entries in flight -> out_valid drops immediately and err_count = 0. The first post-reset output corresponds to the first post-reset input.
